result_collector: RTL and testbench

Downstream stage of the sequence controller. Captures each result word written on the controller's `wr_ram` strobe into an internal buffer of `DEPTH` entries. When the controller signals batch completion, it streams the buffered results out in write order over a valid/ready port. It decouples the multiply/shift pipeline from the slower consumer that reads results back out.

---
 rtl/ca1_pkg.sv | 11 +
 rtl/result_mem.sv | 26 ++
 rtl/result_collector.sv | 122 ++++++++++++
 tb/tb_result_collector.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ca1_pkg.sv
// rtl/ca1_pkg.sv - shared types and defaults for the result collector slice
package ca1_pkg;

    localparam int RESULT_W = 32;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } collector_state_t;

endpackage

// File: rtl/result_mem.sv
// rtl/result_mem.sv - result word storage, sync write / async read, no reset on contents
module result_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // capture one word per write strobe; storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/result_collector.sv
// rtl/result_collector.sv - buffers controller results per batch and streams them out in order
module result_collector
    import ca1_pkg::*;
#(
    parameter int DATA_W = RESULT_W,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_ram,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              batch_done,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    collector_state_t state;
    collector_state_t state_nxt;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             mem_we;
    logic             rd_adv;
    logic             batch_clear;
    logic             ovf_set;

    assign full = (count == CNT_W'(DEPTH));
    assign busy = (state == DRAIN);

    result_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and handshake outputs; a write in the batch_done cycle counts toward the batch
    always_comb begin
        state_nxt   = state;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        mem_we      = 1'b0;
        rd_adv      = 1'b0;
        batch_clear = 1'b0;
        ovf_set     = 1'b0;
        case (state)
            COLLECT: begin
                mem_we  = wr_ram && !full;
                ovf_set = wr_ram && full;
                if (batch_done && ((count != '0) || mem_we)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = (CNT_W'(rd_ptr) == (count - CNT_W'(1)));
                ovf_set   = wr_ram;
                if (out_ready) begin
                    if (out_last) begin
                        batch_clear = 1'b1;
                        state_nxt   = COLLECT;
                    end else begin
                        rd_adv = 1'b1;
                    end
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // pointers, occupancy and sticky overflow; the final transfer empties the whole batch at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (batch_clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (mem_we) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    count  <= count + CNT_W'(1);
                end
                if (rd_adv) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// tb/tb_result_collector.sv - self-checking bench for result_collector
module tb_result_collector;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_ram = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              batch_done = 1'b0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              busy;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic              m_ovf = 1'b0;

    result_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_ram     (wr_ram),
        .wr_data    (wr_data),
        .batch_done (batch_done),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .full       (full),
        .count      (count),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // one write cycle; the model keeps at most DEPTH words per batch
    task automatic push_word(input logic [DATA_W-1:0] d);
        wr_ram  = 1'b1;
        wr_data = d;
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else m_ovf = 1'b1;
        @(negedge clk);
        wr_ram = 1'b0;
    endtask

    task automatic pulse_done();
        batch_done = 1'b1;
        @(negedge clk);
        batch_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b last=%b busy=%b, expected 0/0/0", out_valid, out_last, busy);
        end
        checks++;
        if (count !== '0 || full !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_count: count=%0d full=%b ovf=%b, expected 0/0/0", count, full, overflow);
        end
        rst_n = 1'b1;
        m_ovf = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] words [3] = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 3; i++) begin
            push_word(words[i]);
            checks++;
            if (count !== CNT_W'(i + 1)) begin
                errors++;
                $display("FAIL basic_count: count=%0d, expected %0d", count, i + 1);
            end
        end
        pulse_done();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== exp_q[0] || out_last !== (i == 2)) begin
                errors++;
                $display("FAIL basic_xfer%0d: valid=%b busy=%b data=%h last=%b, expected 1/1/%h/%b",
                         i, out_valid, busy, out_data, out_last, exp_q[0], (i == 2));
            end
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL basic_end: busy=%b valid=%b count=%0d, expected 0/0/0", busy, out_valid, count);
        end
    endtask

    task automatic test_overflow();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) push_word($urandom);
        checks++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full: full=%b ovf=%b, expected 1/0", full, overflow);
        end
        push_word(32'hDEAD_BEEF);
        checks++;
        if (overflow !== 1'b1 || count !== CNT_W'(DEPTH)) begin
            errors++;
            $display("FAIL ovf_sticky: ovf=%b count=%0d, expected 1/%0d", overflow, count, DEPTH);
        end
        pulse_done();
        out_ready = 1'b1;
        while (out_valid === 1'b1 && n < 20) begin
            checks++;
            if (exp_q.size() == 0 || out_data !== exp_q[0] || out_last !== (exp_q.size() == 1)) begin
                errors++;
                $display("FAIL ovf_drain%0d: data=%h last=%b, queue left %0d", n, out_data, out_last, exp_q.size());
            end
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            n++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL ovf_words: drained %0d, expected %0d", n, DEPTH);
        end
    endtask

    task automatic test_empty_batch();
        pulse_done();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL empty_batch%0d: valid=%b busy=%b, expected 0/0", i, out_valid, busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        logic              pat [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [DATA_W-1:0] prev_d = '0;
        logic              prev_l = 1'b0;
        push_word($urandom);
        push_word($urandom);
        pulse_done();
        for (int k = 0; k < 5; k++) begin
            out_ready = pat[k];
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_valid%0d: valid=%b, expected 1", k, out_valid);
            end
            if (k > 0 && !pat[k-1]) begin
                checks++;
                if (out_data !== prev_d || out_last !== prev_l) begin
                    errors++;
                    $display("FAIL stall_hold%0d: data=%h last=%b, expected %h/%b", k, out_data, out_last, prev_d, prev_l);
                end
            end
            if (pat[k]) begin
                checks++;
                if (out_data !== exp_q[0] || out_last !== (exp_q.size() == 1)) begin
                    errors++;
                    $display("FAIL stall_xfer%0d: data=%h last=%b, expected %h/%b", k, out_data, out_last, exp_q[0], exp_q.size() == 1);
                end
                void'(exp_q.pop_front());
            end
            prev_d = out_data;
            prev_l = out_last;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_end: valid=%b busy=%b, expected 0/0", out_valid, busy);
        end
    endtask

    task automatic test_same_cycle();
        push_word($urandom);
        batch_done = 1'b1;
        push_word(32'hAAAA_0001);
        batch_done = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0] || out_last !== (i == 1)) begin
                errors++;
                $display("FAIL same_cycle%0d: valid=%b data=%h last=%b, expected 1/%h/%b", i, out_valid, out_data, out_last, exp_q[0], i == 1);
            end
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_end: valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 4; i++) push_word($urandom);
        pulse_done();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b count=%0d busy=%b, expected 0/0/0", out_valid, count, busy);
        end
        exp_q.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_word(32'h0BAD_F00D);
        pulse_done();
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0BAD_F00D || out_last !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_word: valid=%b data=%h last=%b, expected 1/0badf00d/1", out_valid, out_data, out_last);
        end
        @(negedge clk);
        out_ready = 1'b0;
        exp_q.delete();
        checks++;
        if (out_valid !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL post_reset_end: valid=%b count=%0d, expected 0/0", out_valid, count);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            int n = $urandom_range(0, 10);
            int budget = 0;
            while (n > 0) begin
                if ($urandom_range(0, 3) != 0) begin
                    push_word($urandom);
                    n--;
                end else begin
                    @(negedge clk);
                end
                checks++;
                if (count !== CNT_W'(exp_q.size()) || full !== (exp_q.size() == DEPTH)) begin
                    errors++;
                    $display("FAIL rand_fill%0d: count=%0d full=%b, expected %0d/%b", r, count, full, exp_q.size(), exp_q.size() == DEPTH);
                end
            end
            pulse_done();
            while (exp_q.size() > 0 && budget < 200) begin
                out_ready = $urandom_range(0, 1);
                wr_ram    = ($urandom_range(0, 7) == 0);
                wr_data   = $urandom;
                if (wr_ram) m_ovf = 1'b1;
                checks++;
                if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== exp_q[0] || out_last !== (exp_q.size() == 1)) begin
                    errors++;
                    $display("FAIL rand_drain%0d: valid=%b busy=%b data=%h last=%b, expected 1/1/%h/%b",
                             r, out_valid, busy, out_data, out_last, exp_q[0], exp_q.size() == 1);
                end
                if (out_ready) void'(exp_q.pop_front());
                budget++;
                @(negedge clk);
            end
            wr_ram = 1'b0;
            out_ready = 1'b0;
            if (budget >= 200) begin
                errors++;
                $display("FAIL rand_timeout%0d: %0d words never drained", r, exp_q.size());
                exp_q.delete();
            end
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0 || count !== '0 || overflow !== m_ovf) begin
                errors++;
                $display("FAIL rand_end%0d: busy=%b valid=%b count=%0d ovf=%b, expected 0/0/0/%b",
                         r, busy, out_valid, count, overflow, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_empty_batch();
        test_stall();
        test_same_cycle();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
        $fatal(1);
    end

endmodule
